// File: rtl/dict_entry_serializer.sv
// Streams one 16-word dictionary entry out as 32-bit words, word 0 first.
// Define DICT_SER_PREFETCH_EN to add a one-entry prefetch buffer for gapless streaming.
module dict_entry_serializer #(
   parameter int DATA_WIDTH      = 32,
   parameter int WORDS_PER_ENTRY = 16,
   localparam int IDX_W          = $clog2(WORDS_PER_ENTRY)
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  in_valid,
   input  logic [WORDS_PER_ENTRY*DATA_WIDTH-1:0] in_data,
   output logic                                  in_ready,
   output logic                                  out_valid,
   output logic [DATA_WIDTH-1:0]                 out_data,
   output logic [IDX_W-1:0]                      out_index,
   output logic                                  out_last,
   input  logic                                  out_ready,
   output logic                                  busy
);

   localparam int ENTRY_W = WORDS_PER_ENTRY * DATA_WIDTH;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_ENTRY - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t             r_state;
   logic [ENTRY_W-1:0] r_active;
   logic [IDX_W-1:0]   r_index;

   logic w_in_xfer;
   logic w_out_xfer;
   logic w_last;
   logic w_pf_valid;

`ifdef DICT_SER_PREFETCH_EN
   logic [ENTRY_W-1:0] r_prefetch;
   logic               r_pf_valid;

   assign w_pf_valid = r_pf_valid;
   assign in_ready   = !r_pf_valid;
`else
   assign w_pf_valid = 1'b0;
   assign in_ready   = (r_state == IDLE);
`endif

   assign w_in_xfer  = in_valid & in_ready;
   assign w_out_xfer = out_valid & out_ready;
   assign w_last     = (r_index == LAST_IDX);

   assign out_valid = (r_state == SEND);
   assign out_data  = r_active[r_index*DATA_WIDTH +: DATA_WIDTH];
   assign out_index = r_index;
   assign out_last  = out_valid & w_last;
   assign busy      = out_valid | w_pf_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_active <= '0;
         r_index  <= '0;
`ifdef DICT_SER_PREFETCH_EN
         r_prefetch <= '0;
         r_pf_valid <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_in_xfer) begin
                  r_active <= in_data;
                  r_index  <= '0;
                  r_state  <= SEND;
               end
            end
            SEND: begin
               if (w_out_xfer) begin
                  if (!w_last) begin
                     r_index <= r_index + 1'b1;
                  end else begin
                     r_index <= '0;
`ifdef DICT_SER_PREFETCH_EN
                     // Buffered entry first; else a same-cycle input bypasses the buffer.
                     if (r_pf_valid) begin
                        r_active   <= r_prefetch;
                        r_pf_valid <= 1'b0;
                     end else if (w_in_xfer) begin
                        r_active <= in_data;
                     end else begin
                        r_state <= IDLE;
                     end
`else
                     r_state <= IDLE;
`endif
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
`ifdef DICT_SER_PREFETCH_EN
         if (w_in_xfer && (r_state == SEND) && !(w_out_xfer && w_last)) begin
            r_prefetch <= in_data;
            r_pf_valid <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_dict_entry_serializer.sv
// Self-checking bench for dict_entry_serializer: vector table, directed corners,
// and random traffic against a word-queue reference model.
module tb_dict_entry_serializer;

   localparam int DW = 32;
   localparam int N  = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [N*DW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [3:0]    out_index;
   logic          out_last;
   logic          out_ready;
   logic          busy;

   dict_entry_serializer dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_index (out_index),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: every word still owed to the output, oldest first.
   logic [DW-1:0] q[$];
   bit            lx;
   bit            tr_on = 1'b0;
   bit            vtr[$];
   logic [DW-1:0] dtr[$];

`ifdef DICT_SER_PREFETCH_EN
   localparam bit PF = 1'b1;
`else
   localparam bit PF = 1'b0;
`endif

   typedef struct {
      logic          iv;
      logic          ordy;
      logic          ev;
      logic          eir;
      logic          ebusy;
      logic          elast;
      logic [DW-1:0] edata;
      logic [3:0]    eidx;
   } vec_t;

   vec_t tbl[18];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [N*DW-1:0] mk(input logic [DW-1:0] base);
      logic [N*DW-1:0] e;
      for (int k = 0; k < N; k++) e[k*DW +: DW] = base + DW'(k);
      return e;
   endfunction

   function automatic logic [N*DW-1:0] rnd_entry();
      logic [N*DW-1:0] e;
      for (int k = 0; k < N; k++) e[k*DW +: DW] = $urandom;
      return e;
   endfunction

   // One clock: drive, compare at negedge against the model, advance the model.
   task automatic tick(input logic iv, input logic ordy, input logic [N*DW-1:0] d);
      int  sz;
      int  r;
      bit  ev;
      bit  eir;
      in_valid  = iv;
      out_ready = ordy;
      in_data   = d;
      @(negedge clk);
      sz  = q.size();
      ev  = (sz > 0);
      eir = PF ? (sz <= N) : (sz == 0);
      r   = (sz > N) ? sz - N : sz;
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("in_ready", 64'(in_ready), 64'(eir));
      chk("busy", 64'(busy), 64'(ev));
      if (ev) begin
         chk("out_data", 64'(out_data), 64'(q[0]));
         chk("out_index", 64'(out_index), 64'(N - r));
         chk("out_last", 64'(out_last), 64'(r == 1));
      end
      if (tr_on) begin
         vtr.push_back(out_valid);
         dtr.push_back(out_data);
      end
      lx = iv & eir;
      if (ev && ordy) void'(q.pop_front());
      if (lx) for (int k = 0; k < N; k++) q.push_back(d[k*DW +: DW]);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while (q.size() > 0 && n < 200) begin
         tick(1'b0, 1'b1, '0);
         n++;
      end
      chk({nm, "_drain_timeout"}, 64'(q.size()), 64'd0);
      tick(1'b0, 1'b1, '0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      q.delete();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int ta;
      int tb;
      int b_acc;
      int n;
      logic [N*DW-1:0] ea;
      logic [N*DW-1:0] eb;

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;

      // Vector table: a single entry streamed with out_ready held high.
      tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0};
      for (int i = 1; i <= N; i++)
         tbl[i] = '{1'b0, 1'b1, 1'b1, PF, 1'b1, (i == N),
                    32'hA000_0000 + DW'(i - 1), 4'(i - 1)};
      tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0};

      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_out_last", 64'(out_last), 64'd0);
      chk("reset_out_index", 64'(out_index), 64'd0);
      chk("reset_out_data", 64'(out_data), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("post_reset_in_ready", 64'(in_ready), 64'd1);

      ea = mk(32'hA000_0000);
      for (int i = 0; i < 18; i++) begin
         in_valid  = tbl[i].iv;
         out_ready = tbl[i].ordy;
         in_data   = ea;
         @(negedge clk);
         chk("tbl_out_valid", 64'(out_valid), 64'(tbl[i].ev));
         chk("tbl_in_ready", 64'(in_ready), 64'(tbl[i].eir));
         chk("tbl_busy", 64'(busy), 64'(tbl[i].ebusy));
         if (tbl[i].ev) begin
            chk("tbl_out_data", 64'(out_data), 64'(tbl[i].edata));
            chk("tbl_out_index", 64'(out_index), 64'(tbl[i].eidx));
            chk("tbl_out_last", 64'(out_last), 64'(tbl[i].elast));
         end
         @(posedge clk);
         #1;
      end

      // Backpressure: out_ready pattern 1,0,0,1,0,0,...
      tick(1'b1, 1'b0, mk(32'hC000_0000));
      n = 0;
      while (q.size() > 0 && n < 200) begin
         tick(1'b0, (n % 3) == 0, '0);
         n++;
      end
      chk("bp_timeout", 64'(q.size()), 64'd0);
      tick(1'b0, 1'b1, '0);

      // Back-to-back entries with in_valid held high.
      ea = mk(32'hA000_0000);
      eb = mk(32'hB000_0000);
      vtr.delete();
      dtr.delete();
      tr_on = 1'b1;
      n = 0;
      lx = 1'b0;
      while (!lx && n < 40) begin
         tick(1'b1, 1'b1, ea);
         n++;
      end
      n = 0;
      lx = 1'b0;
      while (!lx && n < 40) begin
         tick(1'b1, 1'b1, eb);
         n++;
      end
      b_acc = vtr.size() - 1;
      drain("b2b");
      tr_on = 1'b0;
      ta = -1;
      tb = -1;
      for (int i = 0; i < vtr.size(); i++)
         if (vtr[i] && dtr[i] == 32'hA000_000F) ta = i;
      for (int i = 0; i < vtr.size(); i++)
         if (tb < 0 && ta >= 0 && i > ta && vtr[i]) tb = i;
      chk("b2b_gap", 64'(tb - ta - 1), PF ? 64'd0 : 64'd1);
      if (tb >= 0) chk("b2b_b_word0", 64'(dtr[tb]), 64'h0000_0000_B000_0000);
      else chk("b2b_b_seen", 64'd0, 64'd1);
      if (PF) chk("b2b_b_accepted_early", 64'(b_acc < ta), 64'd1);

      // in_data changes right after the transfer must not leak into the output.
      tick(1'b1, 1'b0, mk(32'hD000_0000));
      tick(1'b0, 1'b1, mk(32'hEEEE_0000));
      n = 0;
      while (q.size() > 0 && n < 40) begin
         tick(1'b0, 1'b1, mk(32'h5555_0000 + DW'(n << 8)));
         n++;
      end
      drain("sample");

      // Reset after word 5 has been accepted, then a fresh entry.
      tick(1'b1, 1'b1, mk(32'h1111_0000));
      while (q.size() > N - 6) tick(1'b0, 1'b1, '0);
      do_reset();
      tick(1'b1, 1'b1, mk(32'h2222_0000));
      chk("after_reset_first_word", 64'(out_data), 64'h0000_0000_2222_0000);
      chk("after_reset_index", 64'(out_index), 64'd0);
      drain("after_reset");

      // in_valid rises on the cycle the last word transfers.
      tick(1'b1, 1'b1, mk(32'h3333_0000));
      while (q.size() > 1) tick(1'b0, 1'b1, '0);
      tick(1'b1, 1'b1, mk(32'h4444_0000));
      tick(1'b0, 1'b0, '0);
      drain("bypass");

      // Random traffic against the model.
      for (int i = 0; i < 800; i++)
         tick(($urandom % 3) != 0, ($urandom % 4) != 0, rnd_entry());
      drain("random");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dict_entry_serializer.md
Name: dict_entry_serializer

Overview:
- Parallel-to-serial counterpart of the dictionary entry packer.
- Accepts one full 64-byte dictionary entry (16 x 32-bit words) in a single transfer and emits it as 32-bit words, one per accepted handshake.
- Used on the decompression path to stream restored dictionary lines back into the word-level datapath.
- Both sides use valid/ready handshakes.

Parameters:
- DATA_WIDTH, 32, bits per word.
- WORDS_PER_ENTRY, 16, words per entry. Power of two, at least 2.
- IDX_W, $clog2(WORDS_PER_ENTRY), word index width. Derived; not overridden.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a complete entry.
- in_data  input  WORDS_PER_ENTRY*DATA_WIDTH  entry; word k = bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_ready  output  1  block can accept an entry this cycle.
- out_valid  output  1  out_data holds a valid word.
- out_data  output  DATA_WIDTH  current word.
- out_index  output  IDX_W  position of the current word within its entry.
- out_last  output  1  current word is word WORDS_PER_ENTRY-1.
- out_ready  input  1  downstream accepts out_data this cycle.
- busy  output  1  an entry is active or buffered.

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
- Reset values: state=IDLE, out_valid=0, out_last=0, out_index=0, out_data=0, busy=0, active and prefetch entry registers cleared. in_ready=1 once reset deasserts.
- Handshakes: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Transfer semantics: no combinational path from out_ready to out_valid or out_data. in_ready may depend only on registered state.
- IDLE:
  - in_ready=1, out_valid=0.
  - Input transfer: capture in_data into the active register, index=0, go to SEND.
  - Latency: out_valid=1 with word 0 on the next cycle.
- SEND:
  - out_valid=1; out_data = active word[index]; out_index=index; out_last = (index==WORDS_PER_ENTRY-1).
  - Stall (out_ready=0): out_data, out_index and out_last hold stable. in_valid may toggle freely.
  - Output transfer with index < WORDS_PER_ENTRY-1: index increments.
  - Output transfer with index == WORDS_PER_ENTRY-1: index wraps to 0. Next state is set by the Optional Feature; baseline returns to IDLE.
- Word order: word 0 (LSBs) first. This matches the packer, so pack then serialize returns the original word sequence.
- in_data is sampled only on the input transfer cycle; later changes to in_data have no effect.
- busy = (state==SEND) or prefetch entry held.
- Reset mid-entry: remaining words are discarded, no partial output. The first cycle after reset shows out_valid=0.
- Throughput (baseline): in_ready=0 throughout SEND, so one bubble cycle per entry (16 words per 17 cycles at best).

Optional Feature:
- Macro: DICT_SER_PREFETCH_EN.
- Defined:
  - Adds one prefetch entry register with valid bit pf_valid.
  - in_ready = !pf_valid in all states.
  - An input transfer in IDLE loads the active register, as in baseline.
  - An input transfer in SEND loads the prefetch register, unless it coincides with the last-word output transfer while pf_valid=0; then it loads the active register directly (bypass) and the block stays in SEND.
  - On the last-word output transfer with pf_valid=1: prefetch moves to active, pf_valid clears, index=0, and the block stays in SEND. No bubble: word 0 of the next entry is valid the next cycle.
  - Reset clears pf_valid.
- Undefined: baseline behaviour; no prefetch storage.

Test Plan:
- Single entry: reset, in_data word k = 0xA000_0000+k, out_ready=1 constant -> in_ready drops the next cycle; out_data 0xA0000000..0xA000000F on 16 consecutive cycles; out_last only with 0xA000000F; then IDLE, in_ready=1, busy=0.
- Backpressure: out_ready toggles 1,0,0,1,... during an entry -> each word held unchanged while stalled; no word skipped or duplicated; out_index walks 0..15.
- Back-to-back entries with in_valid held high, entries A (0xA000_00kk) and B (0xB000_00kk):
  - Baseline: exactly one out_valid=0 cycle between A's last word and B's word 0.
  - With DICT_SER_PREFETCH_EN: zero gap, and B accepted while A streams.
- Input sampling: change in_data one cycle after the input transfer -> output still equals the captured entry.
- Reset mid-entry: assert reset after word 5 is accepted -> out_valid=0 immediately; after release, the next entry starts at word 0 with out_index=0.
- Prefetch bypass (DICT_SER_PREFETCH_EN): in_valid rises on the cycle word 15 transfers with pf_valid=0 -> the new entry's word 0 appears the next cycle; pf_valid stays 0.
